// File: rtl/fpu_exception_responder.sv
// Turns an FPU exception verdict into the IEEE special result, sticky NV/DZ flags, a saturating count and a trap handshake.
// Latency 1 (registered result); input stalls while result is held (!o_out_ready) or a trap is pending.
module fpu_exception_responder #(
  parameter int unsigned CNT_W      = 8,
  parameter logic [7:0]  QNAN_CANON = 8'h7C
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [1:0]       i_fp_operation,
  input  logic [7:0]       i_op_a,
  input  logic [7:0]       i_op_b,
  input  logic             i_op_is_exception,
  input  logic [2:0]       i_fp_exce,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [7:0]       o_res,
  output logic             o_res_is_special,
  output logic             o_flag_nv,
  output logic             o_flag_dz,
  input  logic             i_flag_clr,
  output logic [CNT_W-1:0] o_exc_cnt,
  input  logic [1:0]       i_trap_en,
  output logic             o_trap_req,
  output logic [1:0]       o_trap_cause,
  input  logic             i_trap_ack
);

  localparam logic [2:0] EXC_QNAN = 3'd1;
  localparam logic [2:0] EXC_SNAN = 3'd2;
  localparam logic [2:0] EXC_INF  = 3'd3;
  localparam logic [2:0] EXC_ZDIV = 3'd4;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {S_IDLE, S_TRAP} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_rst_done;
  logic             r_out_valid;
  logic [7:0]       r_res;
  logic             r_res_special;
  logic             r_flag_nv;
  logic             r_flag_dz;
  logic [CNT_W-1:0] r_exc_cnt;
  logic [1:0]       r_trap_cause;

  logic       w_accept;
  logic       w_a_nan;
  logic       w_a_snan;
  logic       w_b_snan;
  logic       w_a_zero;
  logic [7:0] w_res;
  logic       w_special;
  logic       w_nv;
  logic       w_dz;
  logic       w_trap_hit;
  logic       w_exc_acc;
  logic       w_unused_op;

  // The operation class does not change the special result for the supported codes.
  assign w_unused_op = ^i_fp_operation;

  assign w_a_nan  = (i_op_a[6:3] == 4'hF) && (i_op_a[2:0] != 3'b000);
  assign w_a_snan = w_a_nan && !i_op_a[2];
  assign w_b_snan = (i_op_b[6:3] == 4'hF) && (i_op_b[2:0] != 3'b000) && !i_op_b[2];
  assign w_a_zero = (i_op_a[6:0] == 7'h00);

  always_comb begin
    w_res     = 8'h00;
    w_special = 1'b0;
    w_nv      = 1'b0;
    w_dz      = 1'b0;
    if (i_op_is_exception) begin
      w_special = 1'b1;
      case (i_fp_exce)
        EXC_QNAN: w_res = w_a_nan ? i_op_a : i_op_b;
        EXC_SNAN: begin
          w_res = (w_a_snan || !w_b_snan) && w_a_nan ? (i_op_a | 8'h04) : (i_op_b | 8'h04);
          w_nv  = 1'b1;
        end
        EXC_INF: begin
          w_res = QNAN_CANON;
          w_nv  = 1'b1;
        end
        EXC_ZDIV: begin
          if (w_a_zero) begin
            w_res = QNAN_CANON;
            w_nv  = 1'b1;
          end else begin
            w_res = {i_op_a[7] ^ i_op_b[7], 7'h78};
            w_dz  = 1'b1;
          end
        end
        default: begin
          w_res = QNAN_CANON;
          w_nv  = 1'b1;
        end
      endcase
    end
  end

  assign w_accept   = i_in_valid && o_in_ready;
  assign w_exc_acc  = w_accept && i_op_is_exception;
  assign w_trap_hit = w_accept && ((w_nv && i_trap_en[1]) || (w_dz && i_trap_en[0]));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_trap_hit) w_state_nxt = S_TRAP;
      S_TRAP:  if (i_trap_ack) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_trap_req = (r_state == S_TRAP);
    o_in_ready = r_rst_done && (r_state != S_TRAP) && (!r_out_valid || i_out_ready);
  end

  // r_rst_done keeps the input closed while reset is asserted and opens it one edge later.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rst_done    <= 1'b0;
      r_out_valid   <= 1'b0;
      r_res         <= 8'h00;
      r_res_special <= 1'b0;
      r_trap_cause  <= 2'b00;
    end else begin
      r_rst_done <= 1'b1;
      if (w_accept) begin
        r_out_valid   <= 1'b1;
        r_res         <= w_res;
        r_res_special <= w_special;
      end else if (i_out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (r_state == S_IDLE && w_trap_hit) begin
        r_trap_cause <= {w_nv, w_dz};
      end
    end
  end

  // A clear coinciding with an accepted event leaves only that event's contribution.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_flag_nv <= 1'b0;
      r_flag_dz <= 1'b0;
      r_exc_cnt <= '0;
    end else if (i_flag_clr) begin
      r_flag_nv <= w_accept && w_nv;
      r_flag_dz <= w_accept && w_dz;
      r_exc_cnt <= w_exc_acc ? CNT_W'(1) : '0;
    end else begin
      if (w_accept && w_nv) r_flag_nv <= 1'b1;
      if (w_accept && w_dz) r_flag_dz <= 1'b1;
      if (w_exc_acc && (r_exc_cnt != CNT_MAX)) r_exc_cnt <= r_exc_cnt + CNT_W'(1);
    end
  end

  assign o_out_valid      = r_out_valid;
  assign o_res            = r_res;
  assign o_res_is_special = r_res_special;
  assign o_flag_nv        = r_flag_nv;
  assign o_flag_dz        = r_flag_dz;
  assign o_exc_cnt        = r_exc_cnt;
  assign o_trap_cause     = r_trap_cause;

endmodule

// File: tb/tb_fpu_exception_responder.sv
// Scoreboard bench for fpu_exception_responder: expected results queued on accept, compared on output handshake.
module tb_fpu_exception_responder;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;
  localparam logic [2:0] EXC_QNAN = 3'd1;
  localparam logic [2:0] EXC_SNAN = 3'd2;
  localparam logic [2:0] EXC_INF  = 3'd3;
  localparam logic [2:0] EXC_ZDIV = 3'd4;

  logic       clk = 1'b0;
  logic       i_rst_n = 1'b1;
  logic       i_in_valid = 1'b0;
  logic       o_in_ready;
  logic [1:0] i_fp_operation = 2'd0;
  logic [7:0] i_op_a = 8'h00;
  logic [7:0] i_op_b = 8'h00;
  logic       i_op_is_exception = 1'b0;
  logic [2:0] i_fp_exce = 3'd0;
  logic       o_out_valid;
  logic       i_out_ready = 1'b1;
  logic [7:0] o_res;
  logic       o_res_is_special;
  logic       o_flag_nv;
  logic       o_flag_dz;
  logic       i_flag_clr = 1'b0;
  logic [7:0] o_exc_cnt;
  logic [1:0] i_trap_en = 2'b00;
  logic       o_trap_req;
  logic [1:0] o_trap_cause;
  logic       i_trap_ack = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  logic [8:0] sb_q[$];
  logic m_nv = 1'b0;
  logic m_dz = 1'b0;
  int   m_cnt = 0;

  always #5 clk = ~clk;

  fpu_exception_responder #(.CNT_W(8), .QNAN_CANON(8'h7C)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_fp_operation(i_fp_operation), .i_op_a(i_op_a), .i_op_b(i_op_b),
    .i_op_is_exception(i_op_is_exception), .i_fp_exce(i_fp_exce),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_res(o_res), .o_res_is_special(o_res_is_special),
    .o_flag_nv(o_flag_nv), .o_flag_dz(o_flag_dz), .i_flag_clr(i_flag_clr),
    .o_exc_cnt(o_exc_cnt), .i_trap_en(i_trap_en),
    .o_trap_req(o_trap_req), .o_trap_cause(o_trap_cause), .i_trap_ack(i_trap_ack)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Returns {nv, dz, special, res} for one verdict.
  function automatic logic [10:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic ex, input logic [2:0] code);
    logic a_nan, a_snan, b_snan;
    a_nan  = (a[6:3] == 4'hF) && (a[2:0] != 3'd0);
    a_snan = a_nan && (a[2] == 1'b0);
    b_snan = (b[6:3] == 4'hF) && (b[2:0] != 3'd0) && (b[2] == 1'b0);
    if (!ex) return 11'h000;
    case (code)
      EXC_QNAN: return {2'b00, 1'b1, (a_nan ? a : b)};
      EXC_SNAN: begin
        if (a_snan) return {2'b10, 1'b1, a | 8'h04};
        if (b_snan) return {2'b10, 1'b1, b | 8'h04};
        return {2'b10, 1'b1, (a_nan ? a : b) | 8'h04};
      end
      EXC_INF:  return {2'b10, 1'b1, 8'h7C};
      EXC_ZDIV: begin
        if (a[6:0] == 7'h00) return {2'b10, 1'b1, 8'h7C};
        return {2'b01, 1'b1, a[7] ^ b[7], 7'h78};
      end
      default:  return {2'b10, 1'b1, 8'h7C};
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic ex, input logic [2:0] code);
    i_fp_operation    = op;
    i_op_a            = a;
    i_op_b            = b;
    i_op_is_exception = ex;
    i_fp_exce         = code;
    i_in_valid        = 1'b1;
  endtask

  task automatic wait_accept();
    int n;
    logic [10:0] e;
    n = 0;
    @(negedge clk);
    while (!o_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!o_in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      i_in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      e = model(i_op_a, i_op_b, i_op_is_exception, i_fp_exce);
      sb_q.push_back(e[8:0]);
      if (i_flag_clr) begin
        m_nv  = e[10];
        m_dz  = e[9];
        m_cnt = i_op_is_exception ? 1 : 0;
      end else begin
        m_nv = m_nv | e[10];
        m_dz = m_dz | e[9];
        if (i_op_is_exception && m_cnt < 255) m_cnt++;
      end
      i_in_valid = 1'b0;
      i_flag_clr = 1'b0;
      chk("flag_nv", 32'(o_flag_nv), 32'(m_nv));
      chk("flag_dz", 32'(o_flag_dz), 32'(m_dz));
      chk("exc_cnt", 32'(o_exc_cnt), 32'(m_cnt));
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic ex, input logic [2:0] code);
    drive(op, a, b, ex, code);
    wait_accept();
  endtask

  always @(negedge clk) begin
    logic [8:0] e;
    if (o_out_valid && i_out_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_res", 32'(o_res), 32'(e[7:0]));
        chk("sb_special", 32'(o_res_is_special), 32'(e[8]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 i_rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 32'(o_in_ready), 32'd0);
    chk("rst_out_valid", 32'(o_out_valid), 32'd0);
    chk("rst_res", 32'(o_res), 32'd0);
    chk("rst_flags", 32'({o_flag_nv, o_flag_dz}), 32'd0);
    chk("rst_cnt", 32'(o_exc_cnt), 32'd0);
    chk("rst_trap", 32'({o_trap_req, o_trap_cause}), 32'd0);
    repeat (2) @(posedge clk);
    #1 i_rst_n = 1'b1;
    step();
    chk("ready_after_rst", 32'(o_in_ready), 32'd1);

    // Result mapping across codes and operand patterns
    send(OP_ADD, 8'h78, 8'hF8, 1'b1, EXC_INF);
    chk("inf_valid", 32'(o_out_valid), 32'd1);
    chk("inf_res", 32'(o_res), 32'h7C);
    chk("inf_special", 32'(o_res_is_special), 32'd1);
    chk("inf_nv", 32'(o_flag_nv), 32'd1);
    chk("inf_cnt", 32'(o_exc_cnt), 32'd1);
    send(OP_DIV, 8'h38, 8'h80, 1'b1, EXC_ZDIV);
    chk("zdiv_res", 32'(o_res), 32'hF8);
    chk("zdiv_dz", 32'(o_flag_dz), 32'd1);
    send(OP_DIV, 8'h00, 8'h80, 1'b1, EXC_ZDIV);
    chk("zz_res", 32'(o_res), 32'h7C);
    send(OP_MUL, 8'h79, 8'h38, 1'b1, EXC_SNAN);
    chk("snan_res", 32'(o_res), 32'h7D);
    send(OP_MUL, 8'h7E, 8'h38, 1'b1, EXC_QNAN);
    chk("qnan_res", 32'(o_res), 32'h7E);
    send(OP_ADD, 8'h38, 8'hFE, 1'b1, EXC_QNAN);
    send(OP_ADD, 8'h38, 8'hF9, 1'b1, EXC_SNAN);
    send(OP_SUB, 8'h3C, 8'h40, 1'b0, 3'd0);
    chk("noexc_special", 32'(o_res_is_special), 32'd0);
    send(OP_SUB, 8'h3C, 8'h40, 1'b1, 3'd7);
    send(OP_DIV, 8'hB8, 8'h80, 1'b1, EXC_ZDIV);

    // Backpressure: result held, input stalled, one result per handshake
    step();
    i_out_ready = 1'b0;
    send(OP_MUL, 8'h79, 8'h38, 1'b1, EXC_SNAN);
    drive(OP_DIV, 8'h38, 8'h00, 1'b1, EXC_ZDIV);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(o_in_ready), 32'd0);
      chk("bp_res_hold", 32'(o_res), 32'h7D);
      chk("bp_valid_hold", 32'(o_out_valid), 32'd1);
    end
    step();
    i_out_ready = 1'b1;
    wait_accept();
    chk("bp_next_res", 32'(o_res), 32'h78);

    // Trap on NV with NV trap enabled
    i_trap_en = 2'b10;
    send(OP_ADD, 8'h78, 8'hF8, 1'b1, EXC_INF);
    chk("trap_req", 32'(o_trap_req), 32'd1);
    chk("trap_cause", 32'(o_trap_cause), 32'b10);
    chk("trap_in_ready", 32'(o_in_ready), 32'd0);
    i_trap_en = 2'b00;
    drive(OP_ADD, 8'h3C, 8'h3C, 1'b0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("trap_hold_rdy", 32'(o_in_ready), 32'd0);
      chk("trap_hold_req", 32'(o_trap_req), 32'd1);
      chk("trap_hold_cause", 32'(o_trap_cause), 32'b10);
    end
    i_trap_ack = 1'b1;
    #1;
    chk("ack_cycle_rdy", 32'(o_in_ready), 32'd0);
    step();
    i_trap_ack = 1'b0;
    chk("after_ack_req", 32'(o_trap_req), 32'd0);
    chk("after_ack_rdy", 32'(o_in_ready), 32'd1);
    wait_accept();
    i_trap_en = 2'b10;
    send(OP_DIV, 8'h38, 8'h00, 1'b1, EXC_ZDIV);
    chk("dz_no_trap", 32'(o_trap_req), 32'd0);
    i_trap_en = 2'b00;
    i_trap_ack = 1'b1;
    step();
    i_trap_ack = 1'b0;
    chk("idle_ack_req", 32'(o_trap_req), 32'd0);

    // Standalone clear, saturation, clear coinciding with an event
    i_flag_clr = 1'b1;
    step();
    i_flag_clr = 1'b0;
    m_nv = 1'b0; m_dz = 1'b0; m_cnt = 0;
    chk("clr_cnt", 32'(o_exc_cnt), 32'd0);
    chk("clr_flags", 32'({o_flag_nv, o_flag_dz}), 32'd0);
    for (int i = 0; i < 257; i++) begin
      send(OP_ADD, 8'h7E, 8'h38, 1'b1, EXC_QNAN);
    end
    chk("sat_cnt", 32'(o_exc_cnt), 32'hFF);
    i_flag_clr = 1'b1;
    send(OP_ADD, 8'h78, 8'hF8, 1'b1, EXC_INF);
    chk("clr_evt_cnt", 32'(o_exc_cnt), 32'd1);
    chk("clr_evt_nv", 32'(o_flag_nv), 32'd1);

    // Asynchronous reset while a trap and a result are pending
    i_trap_en = 2'b01;
    send(OP_DIV, 8'h38, 8'h00, 1'b1, EXC_ZDIV);
    chk("pre_rst_trap", 32'({o_trap_req, o_trap_cause}), 32'b101);
    #2 i_rst_n = 1'b0;
    sb_q.delete();
    #1;
    chk("mid_rst_valid", 32'(o_out_valid), 32'd0);
    chk("mid_rst_res", 32'({o_res_is_special, o_res}), 32'd0);
    chk("mid_rst_flags", 32'({o_flag_nv, o_flag_dz}), 32'd0);
    chk("mid_rst_cnt", 32'(o_exc_cnt), 32'd0);
    chk("mid_rst_trap", 32'({o_trap_req, o_trap_cause}), 32'd0);
    chk("mid_rst_rdy", 32'(o_in_ready), 32'd0);
    m_nv = 1'b0; m_dz = 1'b0; m_cnt = 0;
    i_trap_en = 2'b00;
    step();
    step();
    i_rst_n = 1'b1;
    step();
    chk("post_rst_rdy", 32'(o_in_ready), 32'd1);
    send(OP_ADD, 8'h78, 8'hF8, 1'b1, EXC_INF);
    step();
    step();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
